// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the two-digit BCD counter.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam logic [3:0]  BCD_MIN = 4'd0;

    // True when the 4-bit value is a legal decimal digit (0-9).
    function automatic logic is_bcd(input logic [DIGIT_W-1:0] v);
        return (v <= BCD_MAX);
    endfunction

    // Replace an illegal digit by zero so that load never creates states 10-15.
    function automatic logic [DIGIT_W-1:0] sanitize(input logic [DIGIT_W-1:0] v);
        return is_bcd(v) ? v : BCD_MIN;
    endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit.sv
// One decade stage: a BCD digit register with load, increment and decrement.
// carry/borrow flag the 9->0 and 0->9 transitions so the next stage can step.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DIGIT_W-1:0] d,
    input  logic               inc,
    input  logic               dec,
    output logic [DIGIT_W-1:0] q,
    output logic               carry,
    output logic               borrow,
    output logic               bad_load
);

    assign carry    = inc & (q == BCD_MAX);
    assign borrow   = dec & (q == BCD_MIN);
    assign bad_load = load & ~is_bcd(d);

    // Digit register: load has priority, then increment, then decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BCD_MIN;
        end else if (load) begin
            q <= sanitize(d);
        end else if (inc) begin
            q <= (q == BCD_MAX) ? BCD_MIN : (q + 4'd1);
        end else if (dec) begin
            q <= (q == BCD_MIN) ? BCD_MAX : (q - 4'd1);
        end else begin
            q <= q;
        end
    end

endmodule : bcd_digit

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter (00-99) with parallel load, wrap/saturate selection,
// combinational terminal-count strobe and a sticky illegal-load flag.
// Optional macro BCD_CNT_DOWN_EN adds the up_dn port and down counting.
module bcd_counter2
    import bcd_pkg::*;
#(
    parameter logic WRAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               load,
    input  logic [DIGIT_W-1:0] d_ones,
    input  logic [DIGIT_W-1:0] d_tens,
`ifdef BCD_CNT_DOWN_EN
    input  logic               up_dn,
`endif
    output logic [DIGIT_W-1:0] ones,
    output logic [DIGIT_W-1:0] tens,
    output logic               tc,
    output logic               err
);

    logic up_s;
    logic at_max_s;
    logic at_min_s;
    logic term_s;
    logic step_s;
    logic ones_carry_s;
    logic ones_borrow_s;
    logic ones_bad_s;
    logic tens_bad_s;
    logic tens_carry_unused_s;
    logic tens_borrow_unused_s;

`ifdef BCD_CNT_DOWN_EN
    assign up_s = up_dn;
`else
    assign up_s = 1'b1;
`endif

    assign at_max_s = (ones == BCD_MAX) && (tens == BCD_MAX);
    assign at_min_s = (ones == BCD_MIN) && (tens == BCD_MIN);
    assign term_s   = up_s ? at_max_s : at_min_s;

    // tc flags the enabled step that leaves the terminal count, whether or
    // not the counter actually wraps; a load on the same edge suppresses it.
    assign tc = en & ~load & term_s;

    // In saturate mode the step at the terminal count is simply dropped;
    // in wrap mode the digit stages roll over on their own (99->00, 00->99).
    assign step_s = en & ~load & ~(term_s & ~WRAP);

    bcd_digit u_ones (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .d        (d_ones),
        .inc      (step_s & up_s),
        .dec      (step_s & ~up_s),
        .q        (ones),
        .carry    (ones_carry_s),
        .borrow   (ones_borrow_s),
        .bad_load (ones_bad_s)
    );

    bcd_digit u_tens (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .d        (d_tens),
        .inc      (ones_carry_s),
        .dec      (ones_borrow_s),
        .q        (tens),
        .carry    (tens_carry_unused_s),
        .borrow   (tens_borrow_unused_s),
        .bad_load (tens_bad_s)
    );

    // Sticky error: set by any out-of-range load digit, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (ones_bad_s | tens_bad_s) begin
            err <= 1'b1;
        end else begin
            err <= err;
        end
    end

endmodule : bcd_counter2

// File: tb/tb_bcd_counter2.sv
// Self-checking bench for bcd_counter2: a wrapping and a saturating instance
// share the same stimulus; a decimal reference model feeds a scoreboard.
module tb_bcd_counter2;

    typedef struct packed {
        logic [3:0] wt;
        logic [3:0] wo;
        logic [3:0] st;
        logic [3:0] so;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       load;
    logic       up_dn;
    logic [3:0] d_ones;
    logic [3:0] d_tens;
    logic [3:0] ones_w, tens_w, ones_s, tens_s;
    logic       tc_w, tc_s, err_w, err_s;

    int   checks = 0;
    int   errors = 0;
    int   mw;
    int   ms;
    logic m_err;
    logic ex_tc_w;
    logic ex_tc_s;
    exp_t sb_q[$];
    exp_t x;

    always #5 clk = ~clk;

    bcd_counter2 #(.WRAP(1'b1)) dut_w (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .load   (load),
        .d_ones (d_ones),
        .d_tens (d_tens),
`ifdef BCD_CNT_DOWN_EN
        .up_dn  (up_dn),
`endif
        .ones   (ones_w),
        .tens   (tens_w),
        .tc     (tc_w),
        .err    (err_w)
    );

    bcd_counter2 #(.WRAP(1'b0)) dut_s (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .load   (load),
        .d_ones (d_ones),
        .d_tens (d_tens),
`ifdef BCD_CNT_DOWN_EN
        .up_dn  (up_dn),
`endif
        .ones   (ones_s),
        .tens   (tens_s),
        .tc     (tc_s),
        .err    (err_s)
    );

    // Decimal reference model of one counter edge.
    function automatic int nxt(input int v, input logic e, input logic l,
                               input logic [3:0] dt, input logic [3:0] dn,
                               input logic dir, input logic wrap);
        int t;
        int o;
        if (l) begin
            t = (dt > 4'd9) ? 0 : int'(dt);
            o = (dn > 4'd9) ? 0 : int'(dn);
            return t * 10 + o;
        end
        if (!e) return v;
        if (dir) return (v == 99) ? (wrap ? 0 : 99) : v + 1;
        return (v == 0) ? (wrap ? 99 : 0) : v - 1;
    endfunction

    // Apply inputs for one cycle, compute expected tc and push the expected next state.
    task automatic drive(input logic e, input logic l, input logic [3:0] dt,
                         input logic [3:0] dn, input logic dir);
        exp_t p;
        en = e; load = l; d_tens = dt; d_ones = dn; up_dn = dir;
        ex_tc_w = e & ~l & (dir ? (mw == 99) : (mw == 0));
        ex_tc_s = e & ~l & (dir ? (ms == 99) : (ms == 0));
        mw = nxt(mw, e, l, dt, dn, dir, 1'b1);
        ms = nxt(ms, e, l, dt, dn, dir, 1'b0);
        if (l && ((dt > 4'd9) || (dn > 4'd9))) m_err = 1'b1;
        p.wt = 4'(mw / 10); p.wo = 4'(mw % 10);
        p.st = 4'(ms / 10); p.so = 4'(ms % 10);
        p.err = m_err;
        sb_q.push_back(p);
    endtask

    task automatic test_reset();
        checks++;
        if ({tens_w, ones_w, tens_s, ones_s, err_w, err_s, tc_w, tc_s} !== 20'd0) begin
            errors++;
            $display("FAIL reset_state: got %h%h %h%h err %b%b tc %b%b, expected all zero",
                     tens_w, ones_w, tens_s, ones_s, err_w, err_s, tc_w, tc_s);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(1'b0, 1'b1, 4'd3, 4'd7, 1'b1);
            else        drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
            #1;
            checks++;
            if ({tc_w, tc_s} !== {ex_tc_w, ex_tc_s}) begin
                errors++;
                $display("FAIL reset_tc: got %b%b expected %b%b", tc_w, tc_s, ex_tc_w, ex_tc_s);
            end
            @(posedge clk); @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL reset_count: scoreboard empty");
            end else begin
                x = sb_q.pop_front();
                if ({tens_w, ones_w, tens_s, ones_s, err_w, err_s} !== {x.wt, x.wo, x.st, x.so, x.err, x.err}) begin
                    errors++;
                    $display("FAIL reset_count: got %h%h %h%h err %b%b expected %h%h %h%h err %b",
                             tens_w, ones_w, tens_s, ones_s, err_w, err_s, x.wt, x.wo, x.st, x.so, x.err);
                end
            end
        end
        // count is now 39: pulse reset between edges
        en = 1'b0; load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tens_w, ones_w, tens_s, ones_s, err_w, err_s, tc_w, tc_s} !== 20'd0) begin
            errors++;
            $display("FAIL reset_async: got %h%h %h%h err %b%b tc %b%b, expected all zero",
                     tens_w, ones_w, tens_s, ones_s, err_w, err_s, tc_w, tc_s);
        end
        #1 rst_n = 1'b1;
        mw = 0; ms = 0; m_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_up_sweep();
        int tc_hits;
        tc_hits = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
            #1;
            checks++;
            if ({tc_w, tc_s} !== {ex_tc_w, ex_tc_s}) begin
                errors++;
                $display("FAIL sweep_tc: cycle %0d got %b%b expected %b%b", i, tc_w, tc_s, ex_tc_w, ex_tc_s);
            end
            if (tc_w === 1'b1) tc_hits++;
            @(posedge clk); @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL sweep_count: scoreboard empty");
            end else begin
                x = sb_q.pop_front();
                if ({tens_w, ones_w, tens_s, ones_s, err_w, err_s} !== {x.wt, x.wo, x.st, x.so, x.err, x.err}) begin
                    errors++;
                    $display("FAIL sweep_count: cycle %0d got %h%h %h%h err %b%b expected %h%h %h%h err %b",
                             i, tens_w, ones_w, tens_s, ones_s, err_w, err_s, x.wt, x.wo, x.st, x.so, x.err);
                end
            end
        end
        checks++;
        if (tc_hits != 1) begin
            errors++;
            $display("FAIL sweep_tc_count: got %0d tc pulses, expected 1", tc_hits);
        end
        checks++;
        if ({tens_w, ones_w} !== 8'h00) begin
            errors++;
            $display("FAIL sweep_wrap: got %h%h expected 00", tens_w, ones_w);
        end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(1'b0, 1'b1, 4'd9, 4'd8, 1'b1);
            else        drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
            #1;
            checks++;
            if ({tc_w, tc_s} !== {ex_tc_w, ex_tc_s}) begin
                errors++;
                $display("FAIL sat_tc: step %0d got %b%b expected %b%b", i, tc_w, tc_s, ex_tc_w, ex_tc_s);
            end
            @(posedge clk); @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL sat_count: scoreboard empty");
            end else begin
                x = sb_q.pop_front();
                if ({tens_w, ones_w, tens_s, ones_s, err_w, err_s} !== {x.wt, x.wo, x.st, x.so, x.err, x.err}) begin
                    errors++;
                    $display("FAIL sat_count: step %0d got %h%h %h%h err %b%b expected %h%h %h%h err %b",
                             i, tens_w, ones_w, tens_s, ones_s, err_w, err_s, x.wt, x.wo, x.st, x.so, x.err);
                end
            end
        end
        checks++;
        if ({tens_s, ones_s} !== 8'h99) begin
            errors++;
            $display("FAIL sat_hold: got %h%h expected 99", tens_s, ones_s);
        end
        en = 1'b0;
    endtask

    task automatic test_illegal_load();
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      drive(1'b0, 1'b1, 4'hC, 4'h5, 1'b1);
            else if (i == 3) drive(1'b0, 1'b1, 4'd3, 4'hA, 1'b1);
            else             drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b1);
            #1;
            checks++;
            if ({tc_w, tc_s} !== {ex_tc_w, ex_tc_s}) begin
                errors++;
                $display("FAIL illegal_tc: step %0d got %b%b expected %b%b", i, tc_w, tc_s, ex_tc_w, ex_tc_s);
            end
            @(posedge clk); @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL illegal_count: scoreboard empty");
            end else begin
                x = sb_q.pop_front();
                if ({tens_w, ones_w, tens_s, ones_s, err_w, err_s} !== {x.wt, x.wo, x.st, x.so, x.err, x.err}) begin
                    errors++;
                    $display("FAIL illegal_count: step %0d got %h%h %h%h err %b%b expected %h%h %h%h err %b",
                             i, tens_w, ones_w, tens_s, ones_s, err_w, err_s, x.wt, x.wo, x.st, x.so, x.err);
                end
            end
        end
        checks++;
        if (err_w !== 1'b1) begin
            errors++;
            $display("FAIL illegal_sticky: got err %b expected 1", err_w);
        end
        en = 1'b0; load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({err_w, err_s, tens_w, ones_w} !== 10'd0) begin
            errors++;
            $display("FAIL illegal_clear: got err %b%b count %h%h expected err 00 count 00",
                     err_w, err_s, tens_w, ones_w);
        end
        #1 rst_n = 1'b1;
        mw = 0; ms = 0; m_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_vs_en();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(1'b0, 1'b1, 4'd9, 4'd9, 1'b1);
            else        drive(1'b1, 1'b1, 4'd4, 4'd2, 1'b1);
            #1;
            checks++;
            if ({tc_w, tc_s} !== {ex_tc_w, ex_tc_s}) begin
                errors++;
                $display("FAIL loaden_tc: step %0d got %b%b expected %b%b", i, tc_w, tc_s, ex_tc_w, ex_tc_s);
            end
            @(posedge clk); @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL loaden_count: scoreboard empty");
            end else begin
                x = sb_q.pop_front();
                if ({tens_w, ones_w, tens_s, ones_s, err_w, err_s} !== {x.wt, x.wo, x.st, x.so, x.err, x.err}) begin
                    errors++;
                    $display("FAIL loaden_count: step %0d got %h%h %h%h err %b%b expected %h%h %h%h err %b",
                             i, tens_w, ones_w, tens_s, ones_s, err_w, err_s, x.wt, x.wo, x.st, x.so, x.err);
                end
            end
        end
        en = 1'b0; load = 1'b0;
    endtask

`ifdef BCD_CNT_DOWN_EN
    task automatic test_down();
        for (int i = 0; i < 12; i++) begin
            if (i == 0) drive(1'b0, 1'b1, 4'd1, 4'd0, 1'b0);
            else        drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
            #1;
            checks++;
            if ({tc_w, tc_s} !== {ex_tc_w, ex_tc_s}) begin
                errors++;
                $display("FAIL down_tc: step %0d got %b%b expected %b%b", i, tc_w, tc_s, ex_tc_w, ex_tc_s);
            end
            @(posedge clk); @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL down_count: scoreboard empty");
            end else begin
                x = sb_q.pop_front();
                if ({tens_w, ones_w, tens_s, ones_s, err_w, err_s} !== {x.wt, x.wo, x.st, x.so, x.err, x.err}) begin
                    errors++;
                    $display("FAIL down_count: step %0d got %h%h %h%h err %b%b expected %h%h %h%h err %b",
                             i, tens_w, ones_w, tens_s, ones_s, err_w, err_s, x.wt, x.wo, x.st, x.so, x.err);
                end
            end
        end
        checks++;
        if ({tens_w, ones_w, tens_s, ones_s} !== 16'h9900) begin
            errors++;
            $display("FAIL down_wrap: got %h%h %h%h expected 99 00", tens_w, ones_w, tens_s, ones_s);
        end
        en = 1'b0; up_dn = 1'b1;
    endtask
`endif

    task automatic test_back_to_back();
        logic       e;
        logic       l;
        logic       dir;
        logic [3:0] dt;
        logic [3:0] dn;
        for (int i = 0; i < 60; i++) begin
            e  = 1'($urandom_range(0, 3) != 0);
            l  = 1'($urandom_range(0, 5) == 0);
            dt = 4'($urandom_range(0, 11));
            dn = 4'($urandom_range(0, 11));
`ifdef BCD_CNT_DOWN_EN
            dir = 1'($urandom_range(0, 1));
`else
            dir = 1'b1;
`endif
            if (i % 20 == 0) begin
                l = 1'b1; dt = 4'd9; dn = 4'd7;
            end
            drive(e, l, dt, dn, dir);
            #1;
            checks++;
            if ({tc_w, tc_s} !== {ex_tc_w, ex_tc_s}) begin
                errors++;
                $display("FAIL b2b_tc: step %0d got %b%b expected %b%b", i, tc_w, tc_s, ex_tc_w, ex_tc_s);
            end
            @(posedge clk); @(negedge clk);
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL b2b_count: scoreboard empty");
            end else begin
                x = sb_q.pop_front();
                if ({tens_w, ones_w, tens_s, ones_s, err_w, err_s} !== {x.wt, x.wo, x.st, x.so, x.err, x.err}) begin
                    errors++;
                    $display("FAIL b2b_count: step %0d got %h%h %h%h err %b%b expected %h%h %h%h err %b",
                             i, tens_w, ones_w, tens_s, ones_s, err_w, err_s, x.wt, x.wo, x.st, x.so, x.err);
                end
            end
        end
        en = 1'b0; load = 1'b0; up_dn = 1'b1;
    endtask

    // Test sequence.
    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; up_dn = 1'b1;
        d_ones = 4'd0; d_tens = 4'd0;
        mw = 0; ms = 0; m_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_up_sweep();
        test_saturate();
        test_illegal_load();
        test_load_vs_en();
`ifdef BCD_CNT_DOWN_EN
        test_down();
`endif
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bcd_counter2
